// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU sequencing control unit: opcodes,
// instruction field positions, FSM state encoding and field-extract helpers.
package alu_ctrl_pkg;

  localparam int unsigned NumRegs   = 4;
  localparam int unsigned DataWidth = 8;
  localparam int unsigned OpWidth   = 3;
  localparam int unsigned RegAw     = 2;

  // Instruction layout: [7:5] opcode, [4] reserved, [3:2] rd, [1:0] rs
  localparam int unsigned OpMsb   = 7;
  localparam int unsigned OpLsb   = 5;
  localparam int unsigned RsvdBit = 4;
  localparam int unsigned RdMsb   = 3;
  localparam int unsigned RdLsb   = 2;
  localparam int unsigned RsMsb   = 1;
  localparam int unsigned RsLsb   = 0;

  typedef logic [OpWidth-1:0]   opcode_t;
  typedef logic [RegAw-1:0]     reg_addr_t;
  typedef logic [DataWidth-1:0] data_t;

  localparam opcode_t OP_AND  = 3'b000;
  localparam opcode_t OP_ADD  = 3'b001;
  localparam opcode_t OP_OR   = 3'b010;
  localparam opcode_t OP_XOR  = 3'b011;
  localparam opcode_t OP_MOV  = 3'b100;
  localparam opcode_t OP_LDI  = 3'b101;
  localparam opcode_t OP_NOP  = 3'b110;
  localparam opcode_t OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    StFetch = 2'b00,
    StExec  = 2'b01,
    StImm   = 2'b10,
    StHalt  = 2'b11
  } state_e;

  function automatic opcode_t get_op(input data_t instr);
    return instr[OpMsb:OpLsb];
  endfunction

  function automatic reg_addr_t get_rd(input data_t instr);
    return instr[RdMsb:RdLsb];
  endfunction

  function automatic reg_addr_t get_rs(input data_t instr);
    return instr[RsMsb:RsLsb];
  endfunction

  // State entered after an instruction byte is accepted in fetch
  function automatic state_e fetch_next(input opcode_t op);
    state_e st;
    unique case (op)
      OP_AND, OP_ADD, OP_OR, OP_XOR, OP_MOV: st = StExec;
      OP_LDI:                                st = StImm;
      OP_NOP:                                st = StFetch;
      default:                               st = StHalt;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
// Reads during a write return the pre-write contents.
module alu_ctrl_regfile
  import alu_ctrl_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  data_t     wdata_i,
  input  reg_addr_t raddr_a_i,
  output data_t     rdata_a_o,
  input  reg_addr_t raddr_b_i,
  output data_t     rdata_b_o
);

  data_t regs_q [NumRegs];

  // Storage with asynchronous clear and single write port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read ports
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
  end

endmodule

// File: rtl/alu_control_unit.sv
// Sequencing control unit for the 8-bit ALU. Fetches instruction bytes over a
// valid/ready stream, drives ALU operands/select from the latched instruction,
// and writes results back into a 4x8 register file plus carry flag.
// Optional feature macro: ALU_CTRL_RESULT_PORT_EN adds a register-write
// observation port (RESULT_VALID / RESULT_REG / RESULT_DATA).
module alu_control_unit
  import alu_ctrl_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       INSTR_VALID,
  input  logic [7:0] INSTR_DATA,
  output logic       INSTR_READY,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [2:0] ALU_SEL,
  input  logic [7:0] ALU_RESULT,
  input  logic       ALU_C_OUT,
  output logic [7:0] PC,
  output logic       CARRY_FLAG,
  output logic       HALTED
`ifdef ALU_CTRL_RESULT_PORT_EN
  ,
  output logic       RESULT_VALID,
  output logic [1:0] RESULT_REG,
  output logic [7:0] RESULT_DATA
`endif
);

  state_e    state_q, state_d;
  data_t     ir_q;
  data_t     pc_q;
  logic      carry_q;

  logic      xfer;
  logic      ir_load;
  logic      pc_inc;
  logic      carry_load;
  logic      rf_we;
  reg_addr_t rf_waddr;
  data_t     rf_wdata;
  data_t     rf_rdata_a;
  data_t     rf_rdata_b;

  // Reserved instruction bit carries no meaning
  logic unused_rsvd;
  assign unused_rsvd = ir_q[RsvdBit];

  assign xfer = INSTR_VALID & INSTR_READY;

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (xfer) begin
          state_d = fetch_next(get_op(INSTR_DATA));
        end
      end
      StExec:  state_d = StFetch;
      StImm: begin
        if (xfer) begin
          state_d = StFetch;
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // FSM outputs and datapath controls
  always_comb begin
    INSTR_READY = 1'b0;
    HALTED      = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    carry_load  = 1'b0;
    rf_we       = 1'b0;
    rf_waddr    = get_rd(ir_q);
    rf_wdata    = ALU_RESULT;
    unique case (state_q)
      StFetch: begin
        // Ready is held low while reset is asserted
        INSTR_READY = RST_N;
        ir_load     = xfer;
        pc_inc      = xfer;
      end
      StExec: begin
        rf_we      = 1'b1;
        carry_load = 1'b1;
      end
      StImm: begin
        INSTR_READY = RST_N;
        pc_inc      = xfer;
        rf_we       = xfer;
        rf_wdata    = INSTR_DATA;
      end
      StHalt: begin
        HALTED = 1'b1;
      end
      default: ;
    endcase
  end

  // Instruction register, program counter and carry flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ir_q    <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      if (ir_load) begin
        ir_q <= INSTR_DATA;
      end
      if (pc_inc) begin
        pc_q <= pc_q + 8'd1;
      end
      if (carry_load) begin
        carry_q <= ALU_C_OUT;
      end
    end
  end

  alu_ctrl_regfile u_regfile (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (get_rd(ir_q)),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (get_rs(ir_q)),
    .rdata_b_o (rf_rdata_b)
  );

  // ALU drive and architectural outputs
  always_comb begin
    ALU_A      = rf_rdata_a;
    ALU_B      = rf_rdata_b;
    ALU_SEL    = get_op(ir_q);
    PC         = pc_q;
    CARRY_FLAG = carry_q;
  end

`ifdef ALU_CTRL_RESULT_PORT_EN
  // Write observation port, zero in cycles without a register write
  always_comb begin
    RESULT_VALID = rf_we;
    RESULT_REG   = rf_we ? rf_waddr : 2'b00;
    RESULT_DATA  = rf_we ? rf_wdata : 8'h00;
  end
`endif

endmodule

// File: doc/alu_control_unit.md
# alu_control_unit

Sequencing control unit that drives the 8-bit ALU from the other side of its interface. It fetches 8-bit instructions over a valid/ready stream and decodes them into the ALU operand and select inputs. It writes the ALU result and carry back into a 4×8 register file and carry flag, and advances a program counter. It sits between instruction memory and the ALU in the 8-bit processor datapath.

## Interface
- No parameters; register count (4), data width (8) and opcode width (3) are fixed.
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- INSTR_VALID  input  1  instruction/immediate byte available.
- INSTR_DATA  input  8  instruction or immediate byte.
- INSTR_READY  output  1  unit accepts a byte this cycle; a transfer occurs when VALID&READY.
- ALU_A  output  8  operand A = R[rd] of the latched instruction.
- ALU_B  output  8  operand B = R[rs] of the latched instruction.
- ALU_SEL  output  3  ALU operation = opcode of the latched instruction.
- ALU_RESULT  input  8  ALU result.
- ALU_C_OUT  input  1  ALU carry out.
- PC  output  8  count of accepted bytes, instruction and immediate.
- CARRY_FLAG  output  1  carry captured from the last ALU instruction.
- HALTED  output  1  high once HALT has executed.
- RESULT_VALID / RESULT_REG[1:0] / RESULT_DATA[7:0]  output  present only with ALU_CTRL_RESULT_PORT_EN.

## Operation
- Instruction format: [7:5] opcode, [4] reserved (ignored), [3:2] rd, [1:0] rs.
- Opcodes: 000 AND, 001 ADD, 010 OR, 011 XOR, 100 MOV (ALU passes B), 101 LDI, 110 NOP, 111 HALT.
- FSM states and transitions:
  - FETCH: READY=1. On transfer, latch the byte into IR and increment PC.
  - From FETCH, next state by opcode: 000–100 → EXEC, 101 → IMM, 110 → FETCH, 111 → HALT.
  - If VALID is low in FETCH, stay in FETCH with no state change.
- EXEC: READY=0. Write ALU_RESULT to R[rd] and ALU_C_OUT to CARRY_FLAG, then go to FETCH.
  - Logic ops and MOV clear the carry, because the ALU's carry is 0 for them.
- IMM: READY=1. On transfer, write INSTR_DATA to R[rd], increment PC, then go to FETCH. CARRY_FLAG is unchanged.
- HALT: READY=0 and HALTED=1. The unit stays in HALT until reset.
- ALU_A, ALU_B and ALU_SEL are combinational from IR and the register file. They are valid in EXEC and may be ignored in other states.
- rd==rs is legal; the read returns the pre-write value.
- PC wraps from 0xFF to 0x00 silently.

## Timing
- Reset values:
  - State FETCH, IR=0x00, R0–R3=0, PC=0, CARRY_FLAG=0, HALTED=0.
  - INSTR_READY=0 while RST_N is low, and 1 in the first cycle after release.
  - With IR=0x00, ALU_A=ALU_B=0 and ALU_SEL=000.
- ALU instruction: 2 cycles (FETCH transfer, then EXEC). The result is visible in the register file in the cycle after EXEC.
- LDI: 2 transfers, minimum 2 cycles. Stalls while VALID is low.
- NOP: 1 cycle.
- The ALU is combinational, so ALU_RESULT is sampled in the same EXEC cycle it is driven.
- Reset mid-instruction discards IR, any pending immediate and any writeback; all state returns to its reset values asynchronously.

## Configuration
- ALU_CTRL_RESULT_PORT_EN defined:
  - RESULT_VALID pulses for one cycle on every register write, in EXEC or IMM.
  - RESULT_REG and RESULT_DATA carry rd and the written value in that same cycle.
  - All three are 0 at reset and in cycles with no write.
- ALU_CTRL_RESULT_PORT_EN undefined: the three ports and their logic are absent. All other behaviour is identical.

## Structure
- alu_ctrl_pkg holds the opcode constants (OP_AND … OP_HALT), the state enum (FETCH, EXEC, IMM, HALT) and the instruction field bit positions.
- Sub-module alu_ctrl_regfile: 4×8, two combinational read ports, one synchronous write port, same asynchronous active-low reset.

## Test plan
- Reset release, then stream 0xA4,0xF0 (LDI R1,0xF0), 0xA8,0x20 (LDI R2,0x20), 0x26 (ADD R1,R2) → R1=0x10, CARRY_FLAG=1, PC=5.
- Continue with 0x8D (MOV R3,R1) → R3=0x10 and CARRY_FLAG=0. During EXEC, ALU_SEL=100 and ALU_B=0x10.
- 0x65 (XOR R1,R1) → R1=0x00 and CARRY_FLAG=0. rd==rs reads the old value 0x10 in EXEC.
- Insert VALID=0 gaps between 0xA4 and its immediate → unit holds in IMM with READY=1, PC does not advance, and the register is written only on the transfer.
- 0xC0 (NOP) then 0xE0 (HALT) → HALTED=1 and READY=0 permanently, with further VALID bytes ignored. Assert RST_N low → all outputs return to their reset values.
- Assert reset in the EXEC cycle of 0x26 → R1 is not written, CARRY_FLAG=0, PC=0. With ALU_CTRL_RESULT_PORT_EN, each write in the first test pulses RESULT_VALID with the matching RESULT_REG/RESULT_DATA.
